bcd_counter_display: RTL and testbench

Parametrised multi-digit BCD up/down counter with a time-multiplexed seven-segment driver for the board's 8-digit common-anode display. A programmable prescaler produces count ticks. The counter supports direction control, synchronous clear and a wrap indication. The display side scans up to eight digits with optional leading-zero blanking. It is a top-level display block, driving anode_assert and segs pins directly.

---
 rtl/bcd_counter_display.sv | 136 +++++++++++++
 tb/tb_bcd_counter_display.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with a prescaled count tick and a
// time-multiplexed, active-low seven-segment scan driver.
module bcd_counter_display #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned TICK_DIV    = 100_000_000,
   parameter int unsigned REFRESH_DIV = 100_000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      up_down,
   input  logic                      clear,
   output logic [4*NUM_DIGITS-1:0]   count_bcd,
   output logic                      wrap,
   output logic [7:0]                anode_assert,
   output logic [6:0]                segs
);

   localparam int unsigned CNT_W = 4 * NUM_DIGITS;
   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = 3;

   logic [PRE_W-1:0] pre;
   logic [REF_W-1:0] refresh;
   logic [IDX_W-1:0] idx;
   logic             tick;
   logic [CNT_W-1:0] count_next;
   logic             roll;
   logic             carry;
   logic [3:0]       d;
   logic [3:0]       digit;
   logic             blank;
   logic [6:0]       seg_next;
   logic [7:0]       anode_next;

   assign tick = enable && (pre == PRE_W'(TICK_DIV - 1));

   // Ripple BCD step; carry/borrow out of the top digit is the wrap condition.
   always_comb begin
      count_next = count_bcd;
      carry      = 1'b1;
      d          = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = count_bcd[4*i +: 4];
         if (carry) begin
            if (up_down) begin
               if (d == 4'd9) d = 4'd0;
               else begin
                  d     = d + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'd0) d = 4'd9;
               else begin
                  d     = d - 4'd1;
                  carry = 1'b0;
               end
            end
         end
         count_next[4*i +: 4] = d;
      end
      roll = carry;
   end

   // Prescaler, count and wrap; clear outranks both tick and enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre       <= '0;
         count_bcd <= '0;
         wrap      <= 1'b0;
      end else if (clear) begin
         pre       <= '0;
         count_bcd <= '0;
         wrap      <= 1'b0;
      end else if (tick) begin
         pre       <= '0;
         count_bcd <= count_next;
         wrap      <= roll;
      end else begin
         if (enable) pre <= pre + PRE_W'(1);
         wrap <= 1'b0;
      end
   end

   // Free-running dwell counter advancing the scanned digit index.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         refresh <= '0;
         idx     <= '0;
      end else if (refresh == REF_W'(REFRESH_DIV - 1)) begin
         refresh <= '0;
         idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         refresh <= refresh + REF_W'(1);
      end
   end

   // Select the scanned digit and decide whether it is a blanked leading zero.
   always_comb begin
      digit = 4'd0;
      blank = (idx != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) digit = count_bcd[4*i +: 4];
         if ((IDX_W'(i) >= idx) && (count_bcd[4*i +: 4] != 4'd0)) blank = 1'b0;
      end
      anode_next = ~(8'd1 << idx);
      case (digit)
         4'd0:    seg_next = 7'h40;
         4'd1:    seg_next = 7'h79;
         4'd2:    seg_next = 7'h24;
         4'd3:    seg_next = 7'h30;
         4'd4:    seg_next = 7'h19;
         4'd5:    seg_next = 7'h12;
         4'd6:    seg_next = 7'h02;
         4'd7:    seg_next = 7'h78;
         4'd8:    seg_next = 7'h00;
         4'd9:    seg_next = 7'h10;
         default: seg_next = 7'h7F;
      endcase
      if (BLANK_LZ && blank) seg_next = 7'h7F;
   end

   // Anode and segments share one register stage so they never disagree.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         anode_assert <= 8'hFF;
         segs         <= 7'h7F;
      end else begin
         anode_assert <= anode_next;
         segs         <= seg_next;
      end
   end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display: counting, wrap, clear, scan,
// blanking, freeze and asynchronous reset with hand-computed expectations.
module tb_bcd_counter_display;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        up_down;
   logic        clear;
   logic [15:0] count_bcd;
   logic        wrap;
   logic [7:0]  anode_assert;
   logic [6:0]  segs;

   int tests;
   int fails;
   int wrap_hits;

   logic [7:0] exp_an  [8] = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7};
   logic [6:0] exp_seg [8] = '{7'h24, 7'h24, 7'h19, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

   bcd_counter_display #(
      .NUM_DIGITS (4),
      .TICK_DIV   (4),
      .REFRESH_DIV(2),
      .BLANK_LZ   (1'b1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .up_down     (up_down),
      .clear       (clear),
      .count_bcd   (count_bcd),
      .wrap        (wrap),
      .anode_assert(anode_assert),
      .segs        (segs)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      tests = 0; fails = 0; wrap_hits = 0;
      reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0;

      step(3);
      check("rst_count", 32'(count_bcd), 32'h0000);
      check("rst_wrap",  32'(wrap), 32'h0);
      check("rst_anode", 32'(anode_assert), 32'hFF);
      check("rst_segs",  32'(segs), 32'h7F);

      reset = 1'b1; enable = 1'b1;
      for (int cyc = 1; cyc <= 168; cyc++) begin
         step(1);
         if (wrap) wrap_hits++;
         if (cyc == 1)  check("first_anode", 32'(anode_assert), 32'hFE);
         if (cyc == 4)  check("up_4",  32'(count_bcd), 32'h0001);
         if (cyc == 40) check("up_40", 32'(count_bcd), 32'h0010);
      end
      check("up_168", 32'(count_bcd), 32'h0042);
      check("up_nowrap", 32'(wrap_hits), 32'd0);

      enable = 1'b0;
      for (int j = 0; j < 8; j++) begin
         step(1);
         check($sformatf("scan_anode%0d", j), 32'(anode_assert), 32'(exp_an[j]));
         check($sformatf("scan_segs%0d", j),  32'(segs), 32'(exp_seg[j]));
      end
      check("anode_hi", 32'(anode_assert[7:4]), 32'hF);
      check("hold_count", 32'(count_bcd), 32'h0042);

      enable = 1'b1; step(2);
      enable = 1'b0; step(10);
      check("freeze_count", 32'(count_bcd), 32'h0042);
      enable = 1'b1; step(1);
      check("freeze_pre1", 32'(count_bcd), 32'h0042);
      step(1);
      check("freeze_tick", 32'(count_bcd), 32'h0043);

      step(3);
      clear = 1'b1; step(1); clear = 1'b0;
      check("clr_count", 32'(count_bcd), 32'h0000);
      check("clr_wrap",  32'(wrap), 32'h0);
      step(3);
      check("clr_hold3", 32'(count_bcd), 32'h0000);
      step(1);
      check("clr_tick4", 32'(count_bcd), 32'h0001);

      clear = 1'b1; step(1); clear = 1'b0;
      up_down = 1'b0;
      step(3);
      check("dn_pre_count", 32'(count_bcd), 32'h0000);
      check("dn_pre_wrap",  32'(wrap), 32'h0);
      step(1);
      check("dn_count", 32'(count_bcd), 32'h9999);
      check("dn_wrap",  32'(wrap), 32'h1);
      step(1);
      check("dn_wrap_end", 32'(wrap), 32'h0);
      up_down = 1'b1;
      step(2);
      check("upw_pre", 32'(count_bcd), 32'h9999);
      step(1);
      check("upw_count", 32'(count_bcd), 32'h0000);
      check("upw_wrap",  32'(wrap), 32'h1);
      step(1);
      check("upw_wrap_end", 32'(wrap), 32'h0);

      clear = 1'b1; step(1); clear = 1'b0;
      wrap_hits = 0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         step(1);
         if (wrap) wrap_hits++;
      end
      check("up_400", 32'(count_bcd), 32'h0100);
      step(92);
      check("up_123", 32'(count_bcd), 32'h0123);
      check("long_nowrap", 32'(wrap_hits), 32'd0);

      step(2);
      #3 reset = 1'b0;
      #1;
      check("async_count", 32'(count_bcd), 32'h0000);
      check("async_anode", 32'(anode_assert), 32'hFF);
      check("async_segs",  32'(segs), 32'h7F);
      check("async_wrap",  32'(wrap), 32'h0);
      #2 reset = 1'b1;
      step(4);
      check("restart_tick", 32'(count_bcd), 32'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
